// File: rtl/mainfsm_if.sv
// mainfsm_if: instruction fields into, and control outputs out of, the main FSM
interface mainfsm_if;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] State;
  logic       IRWrite;
  logic       NextPC;
  logic       RegW;
  logic       MemW;
  logic       Branch;
  logic       AdrSrc;
  logic [1:0] ResultSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       ALUOp;
  modport master (
    output Op, Funct,
    input  State, IRWrite, NextPC, RegW, MemW, Branch, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUOp
  );
  modport slave (
    input  Op, Funct,
    output State, IRWrite, NextPC, RegW, MemW, Branch, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUOp
  );
endinterface

// File: rtl/mainfsm.sv
// mainfsm: Moore main controller sequencing fetch, decode and execute of the multicycle ARM
module mainfsm (
  input logic      clk,
  input logic      reset,
  mainfsm_if.slave bus
);
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;
  // plain vector so the illegal codes 10-15 stay representable and recover to FETCH
  logic [3:0]  state, next_state;
  logic [11:0] ctrl;
  logic        unused_funct;
  assign unused_funct = &{1'b0, bus.Funct[4:1]};
  // state register; reset wins over any transition
  always_ff @(posedge clk)
    state <= reset ? FETCH : next_state;
  // next-state logic; Op/Funct only matter in DECODE and MEMADR
  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH:              next_state = DECODE;
      DECODE:             next_state = bus.Op == 2'b01 ? MEMADR :
                                       bus.Op == 2'b10 ? BRANCH :
                                       bus.Op == 2'b11 ? FETCH  :
                                       bus.Funct[5]    ? EXECUTEI : EXECUTER;
      MEMADR:             next_state = bus.Funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:            next_state = MEMWB;
      EXECUTER, EXECUTEI: next_state = ALUWB;
      default:            next_state = FETCH;
    endcase
  end
  // output decode from state only: IRWrite NextPC RegW MemW Branch AdrSrc ResultSrc ALUSrcA ALUSrcB ALUOp
  always_comb begin
    ctrl = '0;
    case (state)
      FETCH:    ctrl = 12'b11_000_0_10_1_10_0;
      DECODE:   ctrl = 12'b00_000_0_10_1_10_0;
      MEMADR:   ctrl = 12'b00_000_0_00_0_01_0;
      MEMREAD:  ctrl = 12'b00_000_1_00_0_00_0;
      MEMWB:    ctrl = 12'b00_100_0_01_0_00_0;
      MEMWRITE: ctrl = 12'b00_010_1_00_0_00_0;
      EXECUTER: ctrl = 12'b00_000_0_00_0_00_1;
      EXECUTEI: ctrl = 12'b00_000_0_00_0_01_1;
      ALUWB:    ctrl = 12'b00_100_0_00_0_00_0;
      BRANCH:   ctrl = 12'b00_001_0_10_0_01_0;
      default:  ctrl = '0;
    endcase
  end
  assign bus.State = state;
  assign {bus.IRWrite, bus.NextPC, bus.RegW, bus.MemW, bus.Branch, bus.AdrSrc,
          bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp} = ctrl;
endmodule

// File: tb/tb_mainfsm.sv
// tb_mainfsm: directed walk through every instruction class, reset and illegal-state recovery
module tb_mainfsm;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  mainfsm_if bus ();
  mainfsm dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  // IRWrite NextPC RegW MemW Branch AdrSrc ResultSrc ALUSrcA ALUSrcB ALUOp
  localparam logic [11:0] C_F   = 12'b11_000_0_10_1_10_0;
  localparam logic [11:0] C_D   = 12'b00_000_0_10_1_10_0;
  localparam logic [11:0] C_MA  = 12'b00_000_0_00_0_01_0;
  localparam logic [11:0] C_MR  = 12'b00_000_1_00_0_00_0;
  localparam logic [11:0] C_MWB = 12'b00_100_0_01_0_00_0;
  localparam logic [11:0] C_MW  = 12'b00_010_1_00_0_00_0;
  localparam logic [11:0] C_ER  = 12'b00_000_0_00_0_00_1;
  localparam logic [11:0] C_EI  = 12'b00_000_0_00_0_01_1;
  localparam logic [11:0] C_AW  = 12'b00_100_0_00_0_00_0;
  localparam logic [11:0] C_BR  = 12'b00_001_0_10_0_01_0;
  logic [11:0] ctl;
  assign ctl = {bus.IRWrite, bus.NextPC, bus.RegW, bus.MemW, bus.Branch, bus.AdrSrc,
                bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp};
  task automatic test_reset();
    bus.Op = 2'b00;
    bus.Funct = 6'b000000;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (bus.State !== 4'd0 || ctl !== C_F) begin
      miscompares++;
      $display("FAIL reset: state=%0d ctl=%b, expected state=0 ctl=%b", bus.State, ctl, C_F);
    end
    reset = 1'b0;
  endtask
  task automatic test_dp_reg();
    logic [3:0]  s [5];
    logic [11:0] c [5];
    s = '{4'd0, 4'd1, 4'd6, 4'd8, 4'd0};
    c = '{C_F, C_D, C_ER, C_AW, C_F};
    bus.Op = 2'b00;
    bus.Funct = 6'b000000;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      vectors++;
      if (bus.State !== s[i] || ctl !== c[i]) begin
        miscompares++;
        $display("FAIL dp_reg step %0d: state=%0d ctl=%b, expected state=%0d ctl=%b", i, bus.State, ctl, s[i], c[i]);
      end
    end
  endtask
  task automatic test_dp_imm();
    logic [3:0]  s [5];
    logic [11:0] c [5];
    s = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd0};
    c = '{C_F, C_D, C_EI, C_AW, C_F};
    bus.Op = 2'b00;
    bus.Funct = 6'b100001;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      vectors++;
      if (bus.State !== s[i] || ctl !== c[i]) begin
        miscompares++;
        $display("FAIL dp_imm step %0d: state=%0d ctl=%b, expected state=%0d ctl=%b", i, bus.State, ctl, s[i], c[i]);
      end
    end
  endtask
  task automatic test_back_to_back_ldr_str();
    logic [3:0]  s [10];
    logic [11:0] c [10];
    s = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
    c = '{C_F, C_D, C_MA, C_MR, C_MWB, C_F, C_D, C_MA, C_MW, C_F};
    bus.Op = 2'b01;
    bus.Funct = 6'b011001;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 5) bus.Funct = 6'b011000;
      vectors++;
      if (bus.State !== s[i] || ctl !== c[i]) begin
        miscompares++;
        $display("FAIL ldr_str step %0d: state=%0d ctl=%b, expected state=%0d ctl=%b", i, bus.State, ctl, s[i], c[i]);
      end
    end
  endtask
  task automatic test_branch_undef();
    logic [3:0]  s [6];
    logic [11:0] c [6];
    s = '{4'd0, 4'd1, 4'd9, 4'd0, 4'd1, 4'd0};
    c = '{C_F, C_D, C_BR, C_F, C_D, C_F};
    bus.Op = 2'b10;
    bus.Funct = 6'b000000;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 3) bus.Op = 2'b11;
      vectors++;
      if (bus.State !== s[i] || ctl !== c[i]) begin
        miscompares++;
        $display("FAIL branch_undef step %0d: state=%0d ctl=%b, expected state=%0d ctl=%b", i, bus.State, ctl, s[i], c[i]);
      end
    end
  endtask
  task automatic test_reset_mid_ldr();
    bus.Op = 2'b01;
    bus.Funct = 6'b011001;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.State !== 4'd3) begin
      miscompares++;
      $display("FAIL reset_mid_pre: state=%0d, expected state=3", bus.State);
    end
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.State !== 4'd0 || ctl !== C_F) begin
      miscompares++;
      $display("FAIL reset_mid: state=%0d ctl=%b, expected state=0 ctl=%b", bus.State, ctl, C_F);
    end
    reset = 1'b0;
  endtask
  task automatic test_illegal();
    bus.Op = 2'b11;
    bus.Funct = 6'b000000;
    @(negedge clk);
    force dut.state = 4'd12;
    #1;
    vectors++;
    if (bus.State !== 4'd12 || ctl !== 12'd0) begin
      miscompares++;
      $display("FAIL illegal_out: state=%0d ctl=%b, expected state=12 ctl=%b", bus.State, ctl, 12'd0);
    end
    release dut.state;
    @(negedge clk);
    vectors++;
    if (bus.State !== 4'd0 || ctl !== C_F) begin
      miscompares++;
      $display("FAIL illegal_recover: state=%0d ctl=%b, expected state=0 ctl=%b", bus.State, ctl, C_F);
    end
  endtask
  initial begin
    test_reset();
    test_dp_reg();
    test_dp_imm();
    test_back_to_back_ldr_str();
    test_branch_undef();
    test_reset_mid_ldr();
    test_illegal();
    test_dp_reg();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
